// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the execute stage.
// MUL-class ops finish in 2 cycles; DIV-class ops use a restoring radix-2
// divider producing one quotient bit per cycle (XLEN+1 cycle latency).
// Optional macro MULDIV_FAST_DIV_EN: divide-by-zero and signed-overflow
// divides bypass the iterative path and complete one cycle after accept.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      alu_ctrl_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    // alu_ctrl operation codes handled by this unit
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state;
    logic [4:0]      op;
    logic [XLEN-1:0] a_q, b_q, dvsr, quo, rem;
    logic [CW-1:0]   cnt;

    logic            is_mul_in, is_div_in, sgn_in, accept;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            sa, sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   rem_sh, diff;
    logic            q_bit, is_rem, sgn_op, neg_q, neg_r;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, div_res;
`ifdef MULDIV_FAST_DIV_EN
    logic            special_in, rem_in;
    logic [XLEN-1:0] fast_res;
`endif

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state == S_MUL) || (state == S_DIV);
    assign done_o  = (state == S_DONE) && !flush_i;

    // Request decode and operand magnitudes for the divider
    always_comb begin
        is_mul_in = (alu_ctrl_i == OP_MUL) || (alu_ctrl_i == OP_MULH) ||
                    (alu_ctrl_i == OP_MULHSU) || (alu_ctrl_i == OP_MULHU);
        is_div_in = (alu_ctrl_i == OP_DIV) || (alu_ctrl_i == OP_DIVU) ||
                    (alu_ctrl_i == OP_REM) || (alu_ctrl_i == OP_REMU);
        sgn_in    = (alu_ctrl_i == OP_DIV) || (alu_ctrl_i == OP_REM);
        accept    = valid_i && (state == S_IDLE) && !flush_i && (is_mul_in || is_div_in);
        a_mag     = (sgn_in && op_a_i[XLEN-1]) ? (~op_a_i + 1'b1) : op_a_i;
        b_mag     = (sgn_in && op_b_i[XLEN-1]) ? (~op_b_i + 1'b1) : op_b_i;
`ifdef MULDIV_FAST_DIV_EN
        rem_in     = (alu_ctrl_i == OP_REM) || (alu_ctrl_i == OP_REMU);
        special_in = (op_b_i == '0) ||
                     (sgn_in && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1));
        if (op_b_i == '0)
            fast_res = rem_in ? op_a_i : '1;
        else
            fast_res = rem_in ? '0 : {1'b1, {(XLEN-1){1'b0}}};
`endif
    end

    // Multiplier: operands sign/zero-extended to 2*XLEN, product taken modulo 2^(2*XLEN)
    always_comb begin
        sa      = (op == OP_MULH) || (op == OP_MULHSU);
        sb      = (op == OP_MULH);
        prod    = {{XLEN{sa & a_q[XLEN-1]}}, a_q} * {{XLEN{sb & b_q[XLEN-1]}}, b_q};
        mul_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // One restoring-division step plus final sign fix-up and divide-by-zero override
    always_comb begin
        rem_sh  = {rem, quo[XLEN-1]};
        diff    = rem_sh - {1'b0, dvsr};
        q_bit   = ~diff[XLEN];
        rem_nx  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx  = {quo[XLEN-2:0], q_bit};
        is_rem  = (op == OP_REM) || (op == OP_REMU);
        sgn_op  = (op == OP_DIV) || (op == OP_REM);
        neg_q   = sgn_op && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        neg_r   = sgn_op && a_q[XLEN-1];
        q_fix   = neg_q ? (~quo_nx + 1'b1) : quo_nx;
        r_fix   = neg_r ? (~rem_nx + 1'b1) : rem_nx;
        // Signed overflow needs no override: |min|/1 already yields min with no negation
        if (b_q == '0)
            div_res = is_rem ? a_q : '1;
        else
            div_res = is_rem ? r_fix : q_fix;
    end

    // Control FSM, operand capture, divider datapath and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dvsr     <= '0;
            quo      <= '0;
            rem      <= '0;
            cnt      <= '0;
            result_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op   <= alu_ctrl_i;
                        a_q  <= op_a_i;
                        b_q  <= op_b_i;
                        dvsr <= b_mag;
                        quo  <= a_mag;
                        rem  <= '0;
                        cnt  <= CW'(XLEN - 1);
                        if (!is_div_in) begin
                            state <= S_MUL;
                        end
`ifdef MULDIV_FAST_DIV_EN
                        else if (special_in) begin
                            result_o <= fast_res;
                            state    <= S_DONE;
                        end
`endif
                        else begin
                            state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        result_o <= mul_res;
                        state    <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        quo <= quo_nx;
                        rem <= rem_nx;
                        if (cnt == '0) begin
                            result_o <= div_res;
                            state    <= S_DONE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=32).
// Expected results and latencies come from a 64-bit behavioural model.
module tb_muldiv_unit;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [4:0]  alu_ctrl_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o;

    typedef struct {
        string       tag;
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_res = '0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .alu_ctrl_i(alu_ctrl_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op)
            OP_MUL:    begin p = ua * ub;           return p[31:0];  end
            OP_MULH:   begin p = sa * sb;           return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;           return p[63:32]; end
            OP_DIV:    begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
            OP_REM:    begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
            OP_DIVU:   begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
            OP_REMU:   begin if (b == 0) return a;  p = ua % ub; return p[31:0]; end
            default:   return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_div, special;
        is_div  = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        special = (b == 0) || (((op == OP_DIV) || (op == OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        if (!is_div) return 2;
`ifdef MULDIV_FAST_DIV_EN
        if (special) return 1;
`else
        if (special) return 33;
`endif
        return 33;
    endfunction

    // Issue one op, optionally poke a stray valid while busy, then score the completion
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        exp_t e;
        int   lat, busy_n;
        bit   seen;
        e.tag = tag;
        e.res = model(op, a, b);
        e.lat = model_lat(op, a, b);
        sb_q.push_back(e);
        @(negedge clk);
        valid_i = 1'b1; alu_ctrl_i = op; op_a_i = a; op_b_i = b;
        @(posedge clk);
        lat = 1; busy_n = 0; seen = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        while (!seen && lat < 100) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) busy_n++;
                if (poke && lat == 1) begin
                    valid_i = 1'b1; alu_ctrl_i = OP_MUL; op_a_i = 32'd3; op_b_i = 32'd5;
                end else begin
                    valid_i = 1'b0;
                end
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        valid_i = 1'b0;
        e = sb_q.pop_front();
        check_eq({e.tag, ":done"}, 64'(seen), 64'd1);
        check_eq({e.tag, ":res"}, 64'(result_o), 64'(e.res));
        check_eq({e.tag, ":lat"}, 64'(lat), 64'(e.lat));
        check_eq({e.tag, ":busy"}, 64'(busy_n), 64'(e.lat - 1));
        last_res = e.res;
    endtask

    task automatic count_done(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_o) n++;
        end
        check_eq(tag, 64'(n), 64'd0);
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        valid_i = 1'b1; alu_ctrl_i = OP_DIV; op_a_i = a; op_b_i = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    initial begin
        logic [4:0] ops [8];
        ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(ready_o), 64'd1);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_result", 64'(result_o), 64'd0);
        rst = 1'b0;

        // Unsupported opcode is ignored
        @(negedge clk);
        valid_i = 1'b1; alu_ctrl_i = ALU_ADD; op_a_i = 32'd1; op_b_i = 32'd2;
        @(negedge clk);
        valid_i = 1'b0;
        check_eq("add_ready", 64'(ready_o), 64'd1);
        check_eq("add_busy", 64'(busy_o), 64'd0);
        check_eq("add_done", 64'(done_o), 64'd0);
        check_eq("add_result", 64'(result_o), 64'(last_res));

        // Flush together with valid in IDLE: nothing accepted
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; alu_ctrl_i = OP_MUL; op_a_i = 32'd9; op_b_i = 32'd9;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        check_eq("flushvalid_ready", 64'(ready_o), 64'd1);
        check_eq("flushvalid_busy", 64'(busy_o), 64'd0);

        run_op("mul_7",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op("mulhu_ff",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op("mulh_ff",    OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op("mulhsu_ff",  OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op("div_m7",     OP_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op("rem_m7",     OP_REM,    32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op("divu_100",   OP_DIVU,   32'd100,        32'd7,         1'b0);
        run_op("remu_100",   OP_REMU,   32'd100,        32'd7,         1'b0);
        run_op("divu_z",     OP_DIVU,   32'd5,          32'd0,         1'b0);
        run_op("remu_z",     OP_REMU,   32'd5,          32'd0,         1'b0);
        run_op("div_z",      OP_DIV,    32'hFFFF_FFF0,  32'd0,         1'b0);
        run_op("rem_z",      OP_REM,    32'hFFFF_FFF0,  32'd0,         1'b0);
        run_op("div_ovf",    OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf",    OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op("div_poke",   OP_DIVU,   32'd1000,       32'd33,        1'b1);
        run_op("mul_poke",   OP_MULH,   32'h8000_0000,  32'h8000_0000, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i == 5) ? ($urandom_range(1, 9)) : $urandom;
            run_op($sformatf("rand%0d", i), ops[i], ra, rb, 1'b0);
        end

        // Flush on the 10th DIV cycle
        start_div(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("flush_ready", 64'(ready_o), 64'd1);
        check_eq("flush_busy", 64'(busy_o), 64'd0);
        count_done("flush_nodone", 40);
        check_eq("flush_result", 64'(result_o), 64'(last_res));

        // Flush in DONE suppresses the pulse
        @(negedge clk);
        valid_i = 1'b1; alu_ctrl_i = OP_MUL; op_a_i = 32'd6; op_b_i = 32'd7;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        check_eq("flushdone_done", 64'(done_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("flushdone_ready", 64'(ready_o), 64'd1);
        last_res = 32'd42;

        // Asynchronous reset mid-DIV
        start_div(32'd77, 32'd5);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("arst_result", 64'(result_o), 64'd0);
        check_eq("arst_ready", 64'(ready_o), 64'd1);
        check_eq("arst_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done("arst_nodone", 40);
        last_res = '0;

        run_op("post_rst", OP_REMU, 32'd12345, 32'd100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid_i  input  1  request strobe from execute stage.
REQ-005 SHALL have port alu_ctrl_i  input  ALU_OP  operation code from alu_ctrl (all_pkgs encoding).
REQ-006 SHALL have port op_a_i  input  XLEN  rs1 operand.
REQ-007 SHALL have port op_b_i  input  XLEN  rs2 operand.
REQ-008 SHALL have port flush_i  input  1  abort in-flight op (pipeline flush).
REQ-009 SHALL have port ready_o  output  1  high when a new op can be accepted.
REQ-010 SHALL have port busy_o  output  1  high while computing; drives the pipeline stall.
REQ-011 SHALL have port done_o  output  1  single-cycle completion pulse.
REQ-012 SHALL have port result_o  output  XLEN  result; valid when done_o=1, held until next accept.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE; ready_o=(IDLE), busy_o=(MUL|DIV), done_o=(DONE).
REQ-014 SHALL accept when valid_i=1, state=IDLE, flush_i=0 and alu_ctrl_i is one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; it SHALL register the op and both operands on that edge.
REQ-015 SHALL ignore valid_i carrying any other alu_ctrl_i code, and any valid_i outside IDLE; no state change.
REQ-016 MUL ops: IDLE->MUL->DONE; done_o SHALL assert exactly 2 cycles after the accept edge.
REQ-017 MUL returns product[XLEN-1:0]; MULH signed×signed, MULHSU signed a × unsigned b, MULHU unsigned×unsigned, each returning product[2*XLEN-1:XLEN] of a 2*XLEN-bit product.
REQ-018 DIV ops: restoring radix-2, one quotient bit per cycle; a down-counter loads XLEN-1 on accept; DIV->DONE when the counter reaches 0; done_o SHALL assert XLEN+1 cycles after the accept edge.
REQ-019 Signed DIV/REM SHALL divide magnitudes, then negate quotient if operand signs differ and negate remainder if dividend is negative.
REQ-020 Divide-by-zero: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return the dividend.
REQ-021 Signed overflow (DIV of -2^(XLEN-1) by -1) SHALL return -2^(XLEN-1); the matching REM SHALL return 0.
REQ-022 DONE SHALL always transition to IDLE on the next cycle; done_o is never held more than 1 cycle.
REQ-023 flush_i=1 in MUL, DIV or DONE SHALL force IDLE on the next edge; done_o SHALL be suppressed (0) in that cycle; result_o keeps its prior value.
REQ-024 flush_i and valid_i together in IDLE: flush wins; nothing accepted.
REQ-025 Back-to-back: an accept is legal in the cycle after DONE (state=IDLE); there are no bubbles beyond that.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0, ready_o=1, independent of clk.
REQ-027 Reset mid-operation SHALL discard the op; no done_o SHALL follow its release.

Configuration
REQ-028 Macro MULDIV_FAST_DIV_EN defined: divide-by-zero and signed-overflow cases SHALL go IDLE->DONE directly, so done_o follows the accept edge by 1 cycle.
REQ-029 Macro MULDIV_FAST_DIV_EN undefined: those cases SHALL take the full DIV path (XLEN+1 cycles) with identical result values.

Verification
REQ-030 MUL, a=7, b=0xFFFFFFFD -> result_o=0xFFFFFFEB, done_o exactly 2 cycles after accept, busy_o=1 for 1 cycle.
REQ-031 a=b=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD, done_o at cycle 33; REM with the same operands -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU a=100, b=7 -> 2.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0; latency 1 with MULDIV_FAST_DIV_EN, 33 without.
REQ-034 flush_i pulsed on the 10th DIV cycle -> ready_o=1 on the next cycle, no done_o ever; rst pulsed mid-DIV -> result_o=0 and ready_o=1 before the next clk edge.
REQ-035 valid_i with ALU_ADD, or valid_i while busy_o=1 -> ignored; state, result_o and done_o unchanged.
